// File: rtl/bam_acc_pkg.sv
`default_nettype none
// ==========================================================================
// bam_acc_pkg : shared FSM state type and default sizing for the BAM product accumulator
// Revision    : 1.0
// ==========================================================================
package bam_acc_pkg;

    localparam int ACC_W_DEF    = 20;
    localparam int LEN_DEF      = 32;
    localparam int DROP_LSB_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bam_sat_add.sv
`default_nettype none
// ==========================================================================
// bam_sat_add : combinational unsigned adder that clamps to all-ones on carry-out
// Revision    : 1.0
// ==========================================================================
module bam_sat_add #(
    parameter int W = 10
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] raw_d;

    always_comb begin
        raw_d = {1'b0, a_i} + {1'b0, b_i};
        ovf_o = raw_d[W];
        sum_o = raw_d[W] ? {W{1'b1}} : raw_d[W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/bam_prod_accumulator.sv
`default_nettype none
// ==========================================================================
// bam_prod_accumulator : frames 16-bit approximate products into a saturating sum
// Revision             : 1.0
// ==========================================================================
module bam_prod_accumulator
    import bam_acc_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int LEN      = LEN_DEF,
    parameter int DROP_LSB = DROP_LSB_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_prod,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_sum,
    output logic [$clog2(LEN+1)-1:0]   out_count,
    output logic                       out_sat,
    output logic                       out_lsb_err
);

    localparam int AW = ACC_W - DROP_LSB;
    localparam int CW = $clog2(LEN+1);

    state_t          state_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   count_q;
    logic            out_valid_q;
    logic            sat_q;
    logic            lsb_err_q;
    logic            in_ready_q;

    logic [AW-1:0]   addend_d;
    logic [AW-1:0]   sum_d;
    logic            ovf_d;
    logic [CW-1:0]   count_inc_d;
    logic            lsb_nz_d;
    logic            accept_d;

    // Dropped LSBs are only flagged, never summed.
    assign addend_d    = AW'(in_prod[15:DROP_LSB]);
    assign lsb_nz_d    = |in_prod[DROP_LSB-1:0];
    assign count_inc_d = count_q + CW'(1);
    assign accept_d    = in_valid & in_ready_q;

    bam_sat_add #(
        .W (AW)
    ) u_sat_add (
        .a_i   (acc_q),
        .b_i   (addend_d),
        .sum_o (sum_d),
        .ovf_o (ovf_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            lsb_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        acc_q     <= addend_d;
                        count_q   <= CW'(1);
                        sat_q     <= 1'b0;
                        lsb_err_q <= lsb_nz_d;
                        if (in_last || (LEN == 1)) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (accept_d) begin
                        acc_q     <= sum_d;
                        count_q   <= count_inc_d;
                        sat_q     <= sat_q | ovf_d;
                        lsb_err_q <= lsb_err_q | lsb_nz_d;
                        if (in_last || (count_inc_d == CW'(LEN))) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Ready returns only on the cycle after the handshake.
                    if (out_valid_q && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        sat_q       <= 1'b0;
                        lsb_err_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = {acc_q, {DROP_LSB{1'b0}}};
    assign out_count   = count_q;
    assign out_sat     = sat_q;
    assign out_lsb_err = lsb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bam_prod_accumulator.sv
`default_nettype none
// ==========================================================================
// tb_bam_prod_accumulator : scoreboard bench for the BAM product accumulator
// Revision                : 1.0
// ==========================================================================
module tb_bam_prod_accumulator;

    localparam int ACC_W    = 20;
    localparam int LEN      = 32;
    localparam int DROP_LSB = 10;
    localparam int CW       = $clog2(LEN+1);
    localparam int ACC_MAX  = (1 << (ACC_W - DROP_LSB)) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_prod = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CW-1:0]    out_count;
    logic             out_sat;
    logic             out_lsb_err;

    typedef struct {
        int sum;
        int cnt;
        int sat;
        int err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   m_acc = 0;
    int   m_cnt = 0;
    int   m_sat = 0;
    int   m_err = 0;

    bam_prod_accumulator #(
        .ACC_W    (ACC_W),
        .LEN      (LEN),
        .DROP_LSB (DROP_LSB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_prod     (in_prod),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_count   (out_count),
        .out_sat     (out_sat),
        .out_lsb_err (out_lsb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: updated once per accepted beat.
    task automatic model_beat(input logic [15:0] p, input logic l);
        int add;
        exp_t e;
        add = int'(p >> DROP_LSB);
        if (m_cnt == 0) begin
            m_acc = add;
            m_sat = 0;
            m_err = (p[DROP_LSB-1:0] != 0) ? 1 : 0;
            m_cnt = 1;
        end else begin
            if (m_acc + add > ACC_MAX) begin
                m_acc = ACC_MAX;
                m_sat = 1;
            end else begin
                m_acc = m_acc + add;
            end
            if (p[DROP_LSB-1:0] != 0) m_err = 1;
            m_cnt++;
        end
        if (l || m_cnt == LEN) begin
            e.sum = m_acc * (1 << DROP_LSB);
            e.cnt = m_cnt;
            e.sat = m_sat;
            e.err = m_err;
            sb.push_back(e);
            m_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_prod = 16'($urandom);
            in_last = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_beat(input logic [15:0] p, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            model_beat(p, l);
        end
        in_valid = 1'b0;
        in_prod  = 16'($urandom);
        in_last  = 1'($urandom);
    endtask

    // Waits for a result, stalls it for 'hold' cycles, then handshakes it.
    task automatic wait_result(input int hold);
        int guard;
        logic [ACC_W-1:0] s_sum;
        logic [CW-1:0]    s_cnt;
        logic             s_sat;
        logic             s_err;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) begin
            check("result_timeout", 32'd0, 32'd1);
        end else begin
            s_sum = out_sum;
            s_cnt = out_count;
            s_sat = out_sat;
            s_err = out_lsb_err;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_valid",    32'(out_valid), 32'd1);
                check("hold_sum",      32'(out_sum), 32'(s_sum));
                check("hold_count",    32'(out_count), 32'(s_cnt));
                check("hold_flags",    {30'd0, out_sat, out_lsb_err}, {30'd0, s_sat, s_err});
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("post_hs_valid", 32'(out_valid), 32'd0);
            check("post_hs_ready", 32'(in_ready), 32'd1);
            check("post_hs_flags", {30'd0, out_sat, out_lsb_err}, 32'd0);
        end
    endtask

    // Scoreboard side: compare every completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_sum",     32'(out_sum), 32'(e.sum));
                    check("out_count",   32'(out_count), 32'(e.cnt));
                    check("out_sat",     32'(out_sat), 32'(e.sat));
                    check("out_lsb_err", 32'(out_lsb_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_sum",   32'(out_sum), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_flags", {30'd0, out_sat, out_lsb_err}, 32'd0);
        @(posedge clk); #1;

        // Four beats of 0x0400 closed by in_last.
        for (int i = 0; i < 4; i++) send_beat(16'h0400, i == 3);
        check("exp_sum_4beat", 32'(sb[0].sum), 32'h01000);
        wait_result(0);

        // Full-length saturating frame, no in_last.
        for (int i = 0; i < LEN; i++) send_beat(16'hFC00, 1'b0);
        check("exp_sum_sat", 32'(sb[0].sum), 32'hFFC00);
        wait_result(0);

        // Single beat with non-zero dropped LSBs.
        send_beat(16'h0C05, 1'b1);
        wait_result(0);

        // Count reaching LEN together with in_last ends one frame only.
        for (int i = 0; i < LEN; i++) send_beat(16'h0400, i == LEN - 1);
        wait_result(0);
        idle(4);
        check("no_extra_frame", 32'(out_valid), 32'd0);

        // Stalled result with a beat waiting upstream.
        send_beat(16'h0400, 1'b0);
        send_beat(16'h0400, 1'b1);
        in_valid = 1'b1;
        in_prod  = 16'h0800;
        in_last  = 1'b1;
        wait_result(5);
        send_beat(16'h0800, 1'b1);
        check("exp_sum_fresh", 32'(sb[0].sum), 32'h00800);
        wait_result(0);

        // Random frames with bubbles on the input.
        for (int f = 0; f < 6; f++) begin
            nb = int'($urandom_range(1, 8));
            for (int i = 0; i < nb; i++) begin
                idle(int'($urandom_range(0, 2)));
                send_beat(16'($urandom), i == nb - 1);
            end
            wait_result(int'($urandom_range(0, 3)));
        end

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 3; i++) send_beat(16'h0400, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(out_count), 32'd0);
        check("async_rst_sum",   32'(out_sum), 32'd0);
        m_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(5);
        check("rst_no_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        send_beat(16'h0400, 1'b0);
        send_beat(16'h0400, 1'b1);
        check("exp_sum_after_rst", 32'(sb[0].sum), 32'h00800);
        wait_result(0);

        idle(3);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bam_prod_accumulator.md
BAM_PROD_ACCUMULATOR -- requirements
Module: bam_prod_accumulator

Interface
REQ-001 SHALL provide parameter ACC_W, default 20: accumulator/result width in bits.
REQ-002 SHALL provide parameter LEN, default 32: maximum products per frame.
REQ-003 SHALL provide parameter DROP_LSB, default 10: product LSBs discarded (always zero from an 8x8 BAM with v=10).
REQ-004 SHALL provide ports in this order: clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  product beat valid.
REQ-007 in_ready  out  1  block accepts a beat.
REQ-008 in_prod  in  16  unsigned 16-bit product from the upstream approximate multiplier.
REQ-009 in_last  in  1  marks the final beat of a short frame.
REQ-010 out_valid  out  1  frame result valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_sum  out  ACC_W  accumulated sum, low DROP_LSB bits zero.
REQ-013 out_count  out  clog2(LEN+1)  beats in the frame.
REQ-014 out_sat  out  1  sticky: sum saturated during the frame.
REQ-015 out_lsb_err  out  1  sticky: some accepted in_prod[DROP_LSB-1:0] was non-zero.

Function
REQ-016 SHALL count a beat as accepted only in a cycle where in_valid and in_ready are both 1.
REQ-017 SHALL implement FSM states IDLE, ACC and HOLD; in_ready = 1 in IDLE and ACC, 0 in HOLD.
REQ-018 IDLE, on accept: SHALL load acc = in_prod[15:DROP_LSB] and count = 1, then go to ACC, or to HOLD if in_last = 1 or LEN = 1.
REQ-019 ACC, on accept: SHALL set acc = sat(acc + in_prod[15:DROP_LSB]) and count = count + 1.
REQ-020 ACC, on accept: SHALL go to HOLD when the new count equals LEN or in_last = 1; both true at once SHALL end the frame once.
REQ-021 SHALL hold acc in ACC_W-DROP_LSB bits; on overflow SHALL clamp acc to all-ones and set out_sat.
REQ-022 SHALL drive out_sum = {acc, DROP_LSB zeros}.
REQ-023 SHALL set out_lsb_err for the frame whenever an accepted beat has in_prod[DROP_LSB-1:0] != 0; those bits SHALL NOT be added.
REQ-024 SHALL register all outputs; out_valid SHALL rise the cycle after the final beat is accepted (latency 1).
REQ-025 HOLD: out_sum, out_count, out_sat and out_lsb_err SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-026 On out_valid & out_ready: SHALL clear out_valid and the sticky flags and go to IDLE; in_ready SHALL be 1 in the following cycle, with no same-cycle bypass.
REQ-027 In IDLE and ACC, SHALL ignore in_valid = 0 cycles without changing state; an ACC frame SHALL have no timeout.
REQ-028 SHALL ignore in_prod and in_last when in_valid = 0.

Reset
REQ-029 When rst_n = 0, SHALL asynchronously force state = IDLE, acc = 0, count = 0, out_valid = 0, out_sat = 0, out_lsb_err = 0, out_sum = 0 and out_count = 0, with in_ready = 1 after release.
REQ-030 Reset during ACC or HOLD SHALL discard the partial or pending frame with no output handshake.

Structure
REQ-031 SHALL place the FSM state enum and the default ACC_W, LEN and DROP_LSB constants in a shared package, bam_acc_pkg.
REQ-032 SHALL use one sub-module, bam_sat_add: a combinational unsigned saturating adder of parameter width that outputs sum and overflow.
REQ-033 SHALL keep the multiplier outside this block, driving in_prod from the multiplier output.

Verification
REQ-034 Defaults: four beats of 0x0400, last with in_last=1 -> out_sum=0x01000, out_count=4, out_sat=0, out_lsb_err=0.
REQ-035 Defaults: 32 beats of 0xFC00, no in_last -> frame ends at count 32, out_sum=0xFFC00, out_sat=1.
REQ-036 One beat of 0x0C05 with in_last=1 -> out_sum=0x00C00, out_lsb_err=1, out_count=1.
REQ-037 Result held with out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0 and outputs constant throughout; after the handshake the next beat starts a fresh frame.
REQ-038 rst_n pulsed low after 3 accepted beats -> out_valid never asserts; a following 2-beat frame of 0x0400 -> out_sum=0x00800.
